// File: rtl/snoopy_jump_physics.sv
// Vertical motion engine for Snoopy: gravity, multi-jump, short hop,
// ceiling bonk and runtime floor height, stepped once per frame tick.
module snoopy_jump_physics #(
  parameter int Y_WIDTH      = 8,
  parameter int V_WIDTH      = 6,
  parameter int GROUND_Y     = 100,
  parameter int CEIL_Y       = 10,
  parameter int JUMP_VEL     = 8,
  parameter int GRAVITY      = 1,
  parameter int MAX_FALL_VEL = 8,
  parameter int CUT_VEL      = 2,
  parameter int MAX_JUMPS    = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      tick,
  input  logic                      jump,
  input  logic [Y_WIDTH-1:0]        floor_y,
  output logic [Y_WIDTH-1:0]        snoopy_y,
  output logic signed [V_WIDTH-1:0] vel_y,
  output logic                      airborne,
  output logic [2:0]                jumps_used
);

  localparam int YW = Y_WIDTH + 2;
  localparam int VW = V_WIDTH + 1;

  localparam logic signed [V_WIDTH-1:0] V_JUMP = V_WIDTH'(-JUMP_VEL);
  localparam logic signed [V_WIDTH-1:0] V_CUT  = V_WIDTH'(-CUT_VEL);
  localparam logic signed [V_WIDTH-1:0] V_MAXF = V_WIDTH'(MAX_FALL_VEL);
  localparam logic signed [YW-1:0]      Y_CEIL = YW'(CEIL_Y);
  localparam logic [2:0]                J_MAX  = 3'(MAX_JUMPS);

  typedef enum logic {
    S_GROUND,
    S_AIR
  } state_t;

  state_t                      st_q, st_d;
  logic [Y_WIDTH-1:0]          y_q, y_d;
  logic signed [V_WIDTH-1:0]   vel_q, vel_d;
  logic [2:0]                  jumps_q, jumps_d;
  logic                        jump_prev_q;
  logic                        pend_q, pend_d;

  logic                        pend_now;
  logic signed [YW-1:0]        y_ext;
  logic signed [YW-1:0]        v_ext;
  logic signed [YW-1:0]        floor_ext;
  logic signed [YW-1:0]        y_next;
  logic signed [VW-1:0]        v_grav;
  logic signed [V_WIDTH-1:0]   v_fall;

  always_comb begin
    pend_now  = pend_q | (jump & ~jump_prev_q);
    y_ext     = $signed({2'b00, y_q});
    v_ext     = YW'(vel_q);
    floor_ext = $signed({2'b00, floor_y});
    y_next    = y_ext + v_ext;
    // widened add so gravity can never wrap the velocity
    v_grav    = VW'(vel_q) + VW'(GRAVITY);
    if (v_grav > VW'(V_MAXF)) begin
      v_fall = V_MAXF;
    end else begin
      v_fall = v_grav[V_WIDTH-1:0];
    end
  end

  always_comb begin
    st_d    = st_q;
    y_d     = y_q;
    vel_d   = vel_q;
    jumps_d = jumps_q;
    pend_d  = tick ? 1'b0 : pend_now;
    if (tick) begin
      unique case (st_q)
        S_GROUND: begin
          if (pend_now) begin
            st_d    = S_AIR;
            vel_d   = V_JUMP;
            jumps_d = 3'd1;
          end else if (floor_y > y_q) begin
            st_d    = S_AIR;
            vel_d   = '0;
            jumps_d = 3'd1;
          end else if (floor_y < y_q) begin
            y_d = floor_y;
          end
        end
        S_AIR: begin
          if (y_next >= floor_ext) begin
            st_d    = S_GROUND;
            y_d     = floor_y;
            vel_d   = '0;
            jumps_d = 3'd0;
          end else if (y_next < Y_CEIL) begin
            y_d   = Y_WIDTH'(CEIL_Y);
            vel_d = '0;
          end else begin
            y_d = y_next[Y_WIDTH-1:0];
            if (pend_now && (jumps_q < J_MAX)) begin
              vel_d   = V_JUMP;
              jumps_d = jumps_q + 3'd1;
            end else if (!jump && (vel_q < V_CUT)) begin
              vel_d = V_CUT;
            end else begin
              vel_d = v_fall;
            end
          end
        end
        default: st_d = S_GROUND;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st_q        <= S_GROUND;
      y_q         <= Y_WIDTH'(GROUND_Y);
      vel_q       <= '0;
      jumps_q     <= 3'd0;
      jump_prev_q <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      st_q        <= st_d;
      y_q         <= y_d;
      vel_q       <= vel_d;
      jumps_q     <= jumps_d;
      jump_prev_q <= jump;
      pend_q      <= pend_d;
    end
  end

  assign snoopy_y   = y_q;
  assign vel_y      = vel_q;
  assign airborne   = (st_q == S_AIR);
  assign jumps_used = jumps_q;

endmodule

// File: tb/tb_snoopy_jump_physics.sv
// Bench for snoopy_jump_physics: integer reference model of the
// jump rules, directed scenarios with literal pins, then random play.
module tb_snoopy_jump_physics;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       jump;
  logic [7:0] floor_y;

  logic [7:0]        y0, y1;
  logic signed [5:0] v0, v1;
  logic              a0, a1;
  logic [2:0]        j0, j1;

  int tests = 0;
  int fails = 0;

  int m_y[2], m_v[2], m_air[2], m_ju[2], m_prev[2], m_pend[2];
  int ceil_of[2] = '{10, 80};

  always #5 clk = ~clk;

  snoopy_jump_physics u_dut (
    .clock(clk), .reset(rst), .tick(tick), .jump(jump),
    .floor_y(floor_y), .snoopy_y(y0), .vel_y(v0),
    .airborne(a0), .jumps_used(j0)
  );

  snoopy_jump_physics #(.CEIL_Y(80)) u_ceil (
    .clock(clk), .reset(rst), .tick(tick), .jump(jump),
    .floor_y(floor_y), .snoopy_y(y1), .vel_y(v1),
    .airborne(a1), .jumps_used(j1)
  );

  task automatic compare(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_step(int k);
    int p, yn;
    if (rst) begin
      m_y[k] = 100; m_v[k] = 0; m_air[k] = 0;
      m_ju[k] = 0; m_prev[k] = 0; m_pend[k] = 0;
      return;
    end
    p = (m_pend[k] != 0 || (jump && m_prev[k] == 0)) ? 1 : 0;
    if (tick) begin
      if (m_air[k] == 0) begin
        if (p != 0) begin
          m_air[k] = 1; m_v[k] = -8; m_ju[k] = 1;
        end else if (int'(floor_y) > m_y[k]) begin
          m_air[k] = 1; m_v[k] = 0; m_ju[k] = 1;
        end else if (int'(floor_y) < m_y[k]) begin
          m_y[k] = int'(floor_y);
        end
      end else begin
        yn = m_y[k] + m_v[k];
        if (yn >= int'(floor_y)) begin
          m_y[k] = int'(floor_y); m_v[k] = 0; m_air[k] = 0; m_ju[k] = 0;
        end else if (yn < ceil_of[k]) begin
          m_y[k] = ceil_of[k]; m_v[k] = 0;
        end else begin
          m_y[k] = yn;
          if (p != 0 && m_ju[k] < 2) begin
            m_v[k] = -8; m_ju[k] = m_ju[k] + 1;
          end else if (!jump && m_v[k] < -2) begin
            m_v[k] = -2;
          end else begin
            m_v[k] = (m_v[k] + 1 > 8) ? 8 : m_v[k] + 1;
          end
        end
      end
      m_pend[k] = 0;
    end else begin
      m_pend[k] = p;
    end
    m_prev[k] = jump ? 1 : 0;
  endfunction

  task automatic check_all();
    compare("y0", int'(y0), m_y[0]);
    compare("v0", int'(v0), m_v[0]);
    compare("air0", int'(a0), m_air[0]);
    compare("ju0", int'(j0), m_ju[0]);
    compare("y1", int'(y1), m_y[1]);
    compare("v1", int'(v1), m_v[1]);
    compare("air1", int'(a1), m_air[1]);
    compare("ju1", int'(j1), m_ju[1]);
  endtask

  task automatic step(input bit r, input bit t, input bit j, input int f);
    @(negedge clk);
    rst = r; tick = t; jump = j; floor_y = 8'(f);
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_all();
  endtask

  int apex[8] = '{92, 85, 79, 74, 70, 67, 65, 64};
  int fl;
  bit jl;

  initial begin
    rst = 1'b1; tick = 1'b0; jump = 1'b0; floor_y = 8'd100;
    step(1, 0, 0, 100);
    compare("rst_y", int'(y0), 100);
    compare("rst_v", int'(v0), 0);
    compare("rst_air", int'(a0), 0);
    compare("rst_ju", int'(j0), 0);

    // full jump, ceiling instance bonks on the way up
    step(0, 0, 1, 100);
    step(0, 1, 1, 100);
    compare("take_v", int'(v0), -8);
    compare("take_ju", int'(j0), 1);
    for (int i = 1; i <= 17; i++) begin
      step(0, 1, 1, 100);
      if (i <= 8) compare("apex_y", int'(y0), apex[i-1]);
      if (i == 8) compare("apex_v", int'(v0), 0);
      if (i == 3) begin
        compare("bonk_y", int'(y1), 80);
        compare("bonk_v", int'(v1), 0);
      end
    end
    compare("land_y", int'(y0), 100);
    compare("land_air", int'(a0), 0);
    compare("land_ju", int'(j0), 0);
    compare("bonk_land", int'(y1), 100);

    // short hop
    step(0, 0, 0, 100);
    step(0, 0, 1, 100);
    step(0, 1, 1, 100);
    step(0, 1, 1, 100);
    step(0, 1, 1, 100);
    step(0, 0, 0, 100);
    step(0, 1, 0, 100);
    compare("hop_y", int'(y0), 79);
    compare("hop_v", int'(v0), -2);
    for (int i = 0; i < 30; i++) step(0, 1, 0, 100);
    compare("hop_land", int'(a0), 0);

    // double jump, third press dropped
    step(0, 0, 1, 100);
    step(0, 1, 1, 100);
    for (int i = 1; i <= 7; i++) step(0, 1, 1, 100);
    step(0, 0, 0, 100);
    step(0, 0, 1, 100);
    step(0, 1, 1, 100);
    compare("dj_y", int'(y0), 64);
    compare("dj_v", int'(v0), -8);
    compare("dj_ju", int'(j0), 2);
    step(0, 1, 1, 100);
    step(0, 0, 0, 100);
    step(0, 0, 1, 100);
    step(0, 1, 1, 100);
    compare("tj_y", int'(y0), 49);
    compare("tj_v", int'(v0), -6);
    compare("tj_ju", int'(j0), 2);
    for (int i = 0; i < 40; i++) step(0, 1, 1, 100);
    compare("dj_land", int'(y0), 100);

    // walk off a ledge, then a long fall to terminal velocity
    step(0, 0, 0, 110);
    step(0, 1, 0, 110);
    compare("ledge_air", int'(a0), 1);
    compare("ledge_v", int'(v0), 0);
    compare("ledge_ju", int'(j0), 1);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 110);
    compare("ledge_y", int'(y0), 110);
    step(0, 1, 0, 200);
    for (int i = 1; i <= 9; i++) step(0, 1, 0, 200);
    compare("term_v", int'(v0), 8);
    compare("term_y", int'(y0), 146);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 200);
    compare("deep_y", int'(y0), 200);
    step(0, 1, 0, 100);
    compare("snap_y", int'(y0), 100);

    // reset mid-air with tick and jump high
    step(0, 0, 1, 100);
    step(0, 1, 1, 100);
    step(0, 1, 1, 100);
    step(1, 1, 1, 100);
    compare("mrst_y", int'(y0), 100);
    compare("mrst_v", int'(v0), 0);
    compare("mrst_air", int'(a0), 0);
    step(0, 0, 1, 100);
    compare("held_air", int'(a0), 0);
    step(0, 1, 1, 100);
    compare("held_v", int'(v0), -8);

    // random play; jump only changes on non-tick cycles
    fl = 100;
    jl = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      bit t, r;
      r = ($urandom_range(0, 299) == 0);
      t = ($urandom_range(0, 2) == 0);
      if (!t && $urandom_range(0, 3) == 0) jl = ~jl;
      if ($urandom_range(0, 59) == 0) begin
        if ($urandom_range(0, 1) == 0) fl = 100;
        else fl = int'($urandom_range(15, 250));
      end
      step(r, t, jl, fl);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
